// File: rtl/adder_tree_acc.sv
// N-operand registered adder tree with an optional packet accumulator.
// Valid/ready streaming with full backpressure: every stage freezes when the output is stalled.
module adder_tree_acc #(
  parameter int IS_SIGNED = 1,
  parameter int W         = 8,
  parameter int N         = 4,
  parameter int ACC_GUARD = 8,
  parameter int SAT       = 0,
  localparam int LVL      = $clog2(N),
  localparam int TW       = W + LVL,
  localparam int OW       = TW + ACC_GUARD
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*W-1:0]  in_data,
  input  logic            in_last,
  input  logic            acc_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OW-1:0]   out_data,
  output logic            out_ovf
);

  logic            w_adv;
  logic [TW-1:0]   w_leaf [N];
  // Heap-ordered tree: node 1 is the root, children of node i are 2i and 2i+1.
  // Nodes N/2..N-1 sum pairs of extended operands directly.
  logic [TW-1:0]   r_node [1:N-1];
  logic [LVL-1:0]  r_v;
  logic [LVL-1:0]  r_last;
  logic [LVL-1:0]  r_mode;

  logic [OW-1:0]   r_acc;
  logic            r_sticky;
  logic            r_out_valid;
  logic [OW-1:0]   r_out_data;
  logic            r_out_ovf;

  logic [OW-1:0]   w_ext;
  logic            w_sa;
  logic            w_sb;
  logic [OW:0]     w_full;
  logic            w_ovf;
  logic [OW-1:0]   w_sat;
  logic [OW-1:0]   w_res;

  assign w_adv     = !r_out_valid || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ovf   = r_out_ovf;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      w_leaf[k] = {{LVL{(IS_SIGNED != 0) && in_data[k*W+W-1]}}, in_data[k*W +: W]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < N; i++) r_node[i] <= '0;
      r_v    <= '0;
      r_last <= '0;
      r_mode <= '0;
    end else if (w_adv) begin
      for (int i = N/2; i < N; i++) r_node[i] <= w_leaf[2*i-N] + w_leaf[2*i-N+1];
      for (int i = 1; i < N/2; i++) r_node[i] <= r_node[2*i] + r_node[2*i+1];
      r_v[0]    <= in_valid;
      r_last[0] <= in_last;
      r_mode[0] <= acc_mode;
      for (int j = 1; j < LVL; j++) begin
        r_v[j]    <= r_v[j-1];
        r_last[j] <= r_last[j-1];
        r_mode[j] <= r_mode[j-1];
      end
    end
  end

  // Accumulate add carried one bit wider so both overflow kinds are visible.
  always_comb begin
    w_ext          = {OW{(IS_SIGNED != 0) && r_node[1][TW-1]}};
    w_ext[TW-1:0]  = r_node[1];
    w_sa           = (IS_SIGNED != 0) && r_acc[OW-1];
    w_sb           = (IS_SIGNED != 0) && w_ext[OW-1];
    w_full         = {w_sa, r_acc} + {w_sb, w_ext};
    if (IS_SIGNED != 0) begin
      w_ovf = w_full[OW] != w_full[OW-1];
      w_sat = w_full[OW] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    end else begin
      w_ovf = w_full[OW];
      w_sat = {OW{1'b1}};
    end
    w_res = ((SAT != 0) && w_ovf) ? w_sat : w_full[OW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_sticky    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= 1'b0;
      if (r_v[LVL-1]) begin
        if (!r_mode[LVL-1]) begin
          r_out_data  <= w_ext;
          r_out_ovf   <= 1'b0;
          r_out_valid <= 1'b1;
        end else if (!r_last[LVL-1]) begin
          r_acc    <= w_res;
          r_sticky <= r_sticky | w_ovf;
        end else begin
          r_out_data  <= w_res;
          r_out_ovf   <= r_sticky | w_ovf;
          r_out_valid <= 1'b1;
          r_acc       <= '0;
          r_sticky    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_tree_acc.sv
// Directed bench for adder_tree_acc: four instances (signed, unsigned, signed wrap/sat with no guard)
// share one stimulus stream; each scenario task checks the instances it targets.
module tb_adder_tree_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_last, acc_mode, out_ready;
  logic [31:0] in_data;

  logic s_in_ready, s_out_valid, s_ovf;
  logic u_in_ready, u_out_valid, u_ovf;
  logic w_in_ready, w_out_valid, w_ovf;
  logic c_in_ready, c_out_valid, c_ovf;
  logic [17:0] s_data, u_data;
  logic [9:0]  w_data, c_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_tree_acc #(.IS_SIGNED(1), .W(8), .N(4), .ACC_GUARD(8), .SAT(0)) u_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .in_last(in_last), .acc_mode(acc_mode), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_data), .out_ovf(s_ovf));

  adder_tree_acc #(.IS_SIGNED(0), .W(8), .N(4), .ACC_GUARD(8), .SAT(0)) u_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u_in_ready), .in_data(in_data),
    .in_last(in_last), .acc_mode(acc_mode), .out_valid(u_out_valid), .out_ready(out_ready),
    .out_data(u_data), .out_ovf(u_ovf));

  adder_tree_acc #(.IS_SIGNED(1), .W(8), .N(4), .ACC_GUARD(0), .SAT(0)) u_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready), .in_data(in_data),
    .in_last(in_last), .acc_mode(acc_mode), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_data(w_data), .out_ovf(w_ovf));

  adder_tree_acc #(.IS_SIGNED(1), .W(8), .N(4), .ACC_GUARD(0), .SAT(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready), .in_data(in_data),
    .in_last(in_last), .acc_mode(acc_mode), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_data(c_data), .out_ovf(c_ovf));

  function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic last, input logic mode);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    acc_mode = mode;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    acc_mode = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; acc_mode = 1'b0; out_ready = 1'b1; in_data = '0;
    #3;
    checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", s_out_valid); end
    checks++; if (s_data !== 18'd0) begin errors++; $display("FAIL rst_data got %0d want 0", s_data); end
    checks++; if (s_ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", s_ovf); end
    checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", s_in_ready); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_passthrough();
    send(pack4(127, 127, 127, 127), 1'b0, 1'b0);
    step();
    checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL pass_early got %b want 0", s_out_valid); end
    step();
    checks++; if (s_out_valid !== 1'b1 || s_data !== 18'd508 || s_ovf !== 1'b0) begin
      errors++; $display("FAIL pass_pos got v=%b d=%0d o=%b want v=1 d=508 o=0", s_out_valid, s_data, s_ovf); end
    send(pack4(-128, -128, -128, -128), 1'b0, 1'b0);
    step();
    step();
    checks++; if (s_out_valid !== 1'b1 || s_data !== 18'(-512) || s_ovf !== 1'b0) begin
      errors++; $display("FAIL pass_neg got v=%b d=%h o=%b want v=1 d=%h o=0", s_out_valid, s_data, s_ovf, 18'(-512)); end
    checks++; if (w_data !== 10'h200 || w_ovf !== 1'b0) begin
      errors++; $display("FAIL pass_neg_ow10 got d=%h o=%b want d=200 o=0", w_data, w_ovf); end
  endtask

  task automatic test_unsigned();
    send(pack4(255, 255, 255, 255), 1'b0, 1'b0);
    step();
    step();
    checks++; if (u_out_valid !== 1'b1 || u_data !== 18'd1020 || u_ovf !== 1'b0) begin
      errors++; $display("FAIL uns_max got v=%b d=%0d o=%b want v=1 d=1020 o=0", u_out_valid, u_data, u_ovf); end
    checks++; if (s_data !== 18'(-4)) begin errors++; $display("FAIL sgn_minus1 got %h want %h", s_data, 18'(-4)); end
    send(pack4(1, 2, 3, 4), 1'b0, 1'b0);
    send(pack4(5, 6, 7, 8), 1'b0, 1'b0);
    step();
    checks++; if (u_out_valid !== 1'b1 || u_data !== 18'd10) begin
      errors++; $display("FAIL b2b_first got v=%b d=%0d want v=1 d=10", u_out_valid, u_data); end
    step();
    checks++; if (u_out_valid !== 1'b1 || u_data !== 18'd26) begin
      errors++; $display("FAIL b2b_second got v=%b d=%0d want v=1 d=26", u_out_valid, u_data); end
    step();
  endtask

  task automatic test_accumulate();
    send(pack4(1, 2, 3, 4), 1'b0, 1'b1);
    send(pack4(1, 2, 3, 4), 1'b0, 1'b1);
    send(pack4(1, 2, 3, 4), 1'b1, 1'b1);
    checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL acc_beat1 got v=%b want 0", s_out_valid); end
    step();
    checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL acc_beat2 got v=%b want 0", s_out_valid); end
    step();
    checks++; if (s_out_valid !== 1'b1 || s_data !== 18'd30 || s_ovf !== 1'b0) begin
      errors++; $display("FAIL acc_sum got v=%b d=%0d o=%b want v=1 d=30 o=0", s_out_valid, s_data, s_ovf); end
    step();
    checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL acc_single got v=%b want 0", s_out_valid); end
  endtask

  task automatic test_overflow();
    send(pack4(127, 127, 127, 127), 1'b0, 1'b1);
    send(pack4(127, 127, 127, 127), 1'b1, 1'b1);
    step();
    step();
    checks++; if (w_out_valid !== 1'b1 || w_data !== 10'h3F8 || w_ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_wrap got v=%b d=%h o=%b want v=1 d=3f8 o=1", w_out_valid, w_data, w_ovf); end
    checks++; if (c_out_valid !== 1'b1 || c_data !== 10'h1FF || c_ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_sat got v=%b d=%h o=%b want v=1 d=1ff o=1", c_out_valid, c_data, c_ovf); end
    checks++; if (s_data !== 18'd1016 || s_ovf !== 1'b0) begin
      errors++; $display("FAIL ovf_guarded got d=%0d o=%b want d=1016 o=0", s_data, s_ovf); end
    send(pack4(1, 1, 1, 1), 1'b1, 1'b1);
    step();
    step();
    checks++; if (w_data !== 10'd4 || w_ovf !== 1'b0) begin
      errors++; $display("FAIL ovf_clear_wrap got d=%0d o=%b want d=4 o=0", w_data, w_ovf); end
    checks++; if (c_data !== 10'd4 || c_ovf !== 1'b0) begin
      errors++; $display("FAIL ovf_clear_sat got d=%0d o=%b want d=4 o=0", c_data, c_ovf); end
  endtask

  task automatic test_back_to_back();
    send(pack4(1, 1, 1, 1), 1'b1, 1'b1);
    send(pack4(2, 2, 2, 2), 1'b1, 1'b1);
    step();
    checks++; if (s_out_valid !== 1'b1 || s_data !== 18'd4) begin
      errors++; $display("FAIL pkt_a got v=%b d=%0d want v=1 d=4", s_out_valid, s_data); end
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (s_out_valid !== 1'b1 || s_data !== 18'd4 || s_in_ready !== 1'b0) begin
        errors++; $display("FAIL pkt_a_hold got v=%b d=%0d r=%b want v=1 d=4 r=0", s_out_valid, s_data, s_in_ready); end
    end
    out_ready = 1'b1;
    step();
    checks++; if (s_out_valid !== 1'b1 || s_data !== 18'd8) begin
      errors++; $display("FAIL pkt_b got v=%b d=%0d want v=1 d=8", s_out_valid, s_data); end
    step();
    checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL pkt_b_once got v=%b want 0", s_out_valid); end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int rcv = 0;
    int cyc = 0;
    logic prev_stall = 1'b0;
    logic [17:0] prev_data = '0;
    while (rcv < 8 && cyc < 200) begin
      @(posedge clk);
      #1;
      if (prev_stall) begin
        checks++; if (s_out_valid !== 1'b1 || s_data !== prev_data) begin
          errors++; $display("FAIL bp_stable got v=%b d=%0d want v=1 d=%0d", s_out_valid, s_data, prev_data); end
      end
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 8) begin
        in_valid = 1'b1; acc_mode = 1'b0; in_last = 1'b0;
        in_data  = pack4(sent * 10, sent, -5, 3);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      checks++; if (s_in_ready !== (!s_out_valid || out_ready)) begin
        errors++; $display("FAIL bp_in_ready got %b want %b", s_in_ready, !s_out_valid || out_ready); end
      if (in_valid && s_in_ready) sent++;
      if (s_out_valid && out_ready) begin
        checks++; if (s_data !== 18'(11 * rcv - 2)) begin
          errors++; $display("FAIL bp_order idx %0d got %0d want %0d", rcv, $signed(s_data), 11 * rcv - 2); end
        rcv++;
      end
      prev_stall = s_out_valid && !out_ready;
      prev_data  = s_data;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++; if (rcv != 8) begin errors++; $display("FAIL bp_count got %0d want 8", rcv); end
    step();
    step();
    checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got v=%b want 0", s_out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send(pack4(5, 5, 5, 5), 1'b0, 1'b0);
    send(pack4(1, 2, 3, 4), 1'b0, 1'b1);
    send(pack4(1, 2, 3, 4), 1'b0, 1'b1);
    checks++; if (s_out_valid !== 1'b1 || s_data !== 18'd20) begin
      errors++; $display("FAIL pre_reset got v=%b d=%0d want v=1 d=20", s_out_valid, s_data); end
    rst_n = 1'b0;
    #1;
    checks++; if (s_out_valid !== 1'b0 || s_data !== 18'd0 || s_ovf !== 1'b0 || s_in_ready !== 1'b1) begin
      errors++; $display("FAIL async_reset got v=%b d=%0d o=%b r=%b want 0 0 0 1", s_out_valid, s_data, s_ovf, s_in_ready); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(pack4(1, 1, 1, 1), 1'b1, 1'b1);
    step();
    step();
    checks++; if (s_out_valid !== 1'b1 || s_data !== 18'd4 || s_ovf !== 1'b0) begin
      errors++; $display("FAIL post_reset got v=%b d=%0d o=%b want v=1 d=4 o=0", s_out_valid, s_data, s_ovf); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_unsigned();
    test_accumulate();
    test_overflow();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
